// File: rtl/vga_timing_gen.sv
// VGA scan timing: DrawX/DrawY position, active-low hs/vs, blank (1 = active video),
// PIPE_DELAY-matched copies of hs/vs/blank, frame_start pulse and animation frame index.
// Every output is a flop. Sync/blank are decoded from the next counter values so they line up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2,
  parameter int ANIM_DIV   = 8,
  parameter int ANIM_W     = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              blank,
  output logic              hs,
  output logic              vs,
  output logic              hs_d,
  output logic              vs_d,
  output logic              blank_d,
  output logic              frame_start,
  output logic [ANIM_W-1:0] anim_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [6:0] FCNT_LAST = 7'(ANIM_DIV - 1);

  // Reject parameter sets the 10-bit counters or the fixed-size state cannot hold.
  generate
    if (H_ACTIVE < 1 || H_FP < 0 || H_SYNC < 1 || H_BP < 0 || H_TOTAL > 1023 ||
        V_ACTIVE < 1 || V_FP < 0 || V_SYNC < 1 || V_BP < 0 || V_TOTAL > 1023 ||
        PIPE_DELAY < 1 || PIPE_DELAY > 4 || ANIM_DIV < 1 || ANIM_DIV > 64 || ANIM_W < 1) begin : g_bad_params
      $error("vga_timing_gen: parameter out of range");
    end
  endgenerate

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       blank_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       fs_nxt;

  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] blank_pipe;
  logic [6:0]            fcnt;

  // Next scan position: X wraps every line, Y advances only on an X wrap.
  always_comb begin
    x_nxt = DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == H_LAST) begin
      x_nxt = 10'd0;
      y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Decode sync/blank/frame_start from the next position so they register alongside it.
  always_comb begin
    blank_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    hs_nxt    = !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
    vs_nxt    = !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
    fs_nxt    = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  // Position counters and aligned timing outputs; reset parks at the last pixel so
  // the first edge after release lands on pixel (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= blank_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      frame_start <= fs_nxt;
    end
  end

  // Delay line matching the downstream ROM+palette latency; cleared to idle on reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      blank_pipe <= '0;
    end else begin
      hs_pipe[0]    <= hs;
      vs_pipe[0]    <= vs;
      blank_pipe[0] <= blank;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
        blank_pipe[i] <= blank_pipe[i-1];
      end
    end
  end

  assign hs_d    = hs_pipe[PIPE_DELAY-1];
  assign vs_d    = vs_pipe[PIPE_DELAY-1];
  assign blank_d = blank_pipe[PIPE_DELAY-1];

  // Frame counter and animation index; both update on the edge that raises frame_start.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      fcnt       <= 7'd0;
      anim_frame <= '0;
    end else if (fs_nxt) begin
      if (fcnt == FCNT_LAST) begin
        fcnt       <= 7'd0;
        anim_frame <= anim_frame + ANIM_W'(1);
      end else begin
        fcnt <= fcnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (35x17) so many frames fit in a short run.
// Three instances differ in PIPE_DELAY and animation setup; expectations come from position arithmetic.
// Directed reset/run steps plus randomized reset points and run lengths.
module tb_vga_timing_gen;

  localparam int HA = 20, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 35
  localparam int VT = VA + VFP + VSW + VBP;   // 17
  localparam int FR = HT * VT;                // 595 cycles per frame

  // instance A: delay 2, anim /8 width 2; B: delay 4, anim /1 width 3; C: delay 1, anim /3 width 2
  localparam int PD_A = 2, AD_A = 8, AW_A = 2;
  localparam int PD_B = 4, AD_B = 1, AW_B = 3;
  localparam int PD_C = 1, AD_C = 3, AW_C = 2;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_bl, a_hs, a_vs, a_hsd, a_vsd, a_bld, a_fs;
  logic b_bl, b_hs, b_vs, b_hsd, b_vsd, b_bld, b_fs;
  logic c_bl, c_hs, c_vs, c_hsd, c_vsd, c_bld, c_fs;
  logic [AW_A-1:0] a_anim;
  logic [AW_B-1:0] b_anim;
  logic [AW_C-1:0] c_anim;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .PIPE_DELAY(PD_A), .ANIM_DIV(AD_A), .ANIM_W(AW_A)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .hs(a_hs), .vs(a_vs), .hs_d(a_hsd), .vs_d(a_vsd), .blank_d(a_bld),
    .frame_start(a_fs), .anim_frame(a_anim));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .PIPE_DELAY(PD_B), .ANIM_DIV(AD_B), .ANIM_W(AW_B)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .hs(b_hs), .vs(b_vs), .hs_d(b_hsd), .vs_d(b_vsd), .blank_d(b_bld),
    .frame_start(b_fs), .anim_frame(b_anim));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .PIPE_DELAY(PD_C), .ANIM_DIV(AD_C), .ANIM_W(AW_C)) dut_c (
    .vga_clk(vga_clk), .reset(reset), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
    .hs(c_hs), .vs(c_vs), .hs_d(c_hsd), .vs_d(c_vsd), .blank_d(c_bld),
    .frame_start(c_fs), .anim_frame(c_anim));

  int checks = 0;
  int errors = 0;

  // reference model state: t = cycles since release (-1 while in reset)
  int t = -1;
  logic [2:0] hist [0:4];   // {hs,vs,blank} history, hist[0] = this cycle

  // expected values for the current cycle
  int   e_x, e_y, e_fa, e_fb, e_fc;
  logic e_bl, e_hs, e_vs, e_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Advance one clock with the given reset level, update the model, compare all outputs.
  task automatic step(input bit rst);
    int p, frames;
    reset = rst;
    @(posedge vga_clk);
    #1;
    if (rst) begin
      t = -1;
      for (int i = 0; i < 5; i++) hist[i] = 3'b110;
      e_x = HT - 1; e_y = VT - 1;
      e_bl = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      e_fa = 0; e_fb = 0; e_fc = 0;
    end else begin
      t++;
      p  = t % FR;
      e_x = p % HT;
      e_y = p / HT;
      e_bl = (e_x < HA) && (e_y < VA);
      e_hs = !((e_x >= HA + HFP) && (e_x < HA + HFP + HSW));
      e_vs = !((e_y >= VA + VFP) && (e_y < VA + VFP + VSW));
      e_fs = (p == 0);
      frames = t / FR + 1;  // frame_start pulses seen so far, including this frame
      e_fa = (frames / AD_A) % (1 << AW_A);
      e_fb = (frames / AD_B) % (1 << AW_B);
      e_fc = (frames / AD_C) % (1 << AW_C);
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {e_hs, e_vs, e_bl};
    end
    chk("a_DrawX", 32'(a_x), 32'(e_x));
    chk("a_DrawY", 32'(a_y), 32'(e_y));
    chk("a_blank", 32'(a_bl), 32'(e_bl));
    chk("a_hs", 32'(a_hs), 32'(e_hs));
    chk("a_vs", 32'(a_vs), 32'(e_vs));
    chk("a_frame_start", 32'(a_fs), 32'(e_fs));
    chk("a_anim", 32'(a_anim), 32'(e_fa));
    chk("a_hs_d", 32'(a_hsd), 32'(hist[PD_A][2]));
    chk("a_vs_d", 32'(a_vsd), 32'(hist[PD_A][1]));
    chk("a_blank_d", 32'(a_bld), 32'(hist[PD_A][0]));
    chk("b_pos", {12'd0, b_x, b_y}, {12'd0, 10'(e_x), 10'(e_y)});
    chk("b_sync", {29'd0, b_hs, b_vs, b_bl}, {29'd0, e_hs, e_vs, e_bl});
    chk("b_frame_start", 32'(b_fs), 32'(e_fs));
    chk("b_anim", 32'(b_anim), 32'(e_fb));
    chk("b_delayed", {29'd0, b_hsd, b_vsd, b_bld}, {29'd0, hist[PD_B]});
    chk("c_pos", {12'd0, c_x, c_y}, {12'd0, 10'(e_x), 10'(e_y)});
    chk("c_frame_start", 32'(c_fs), 32'(e_fs));
    chk("c_anim", 32'(c_anim), 32'(e_fc));
    chk("c_delayed", {29'd0, c_hsd, c_vsd, c_bld}, {29'd0, hist[PD_C]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) hist[i] = 3'b110;

    // reset held three cycles, then release and run into frame 17 (anim A = 2)
    step(1'b1); step(1'b1); step(1'b1);
    run(16 * FR + 7 * HT + 11);

    // mid-frame reset at a running position, release, and run long enough to wrap anim A
    step(1'b1);
    run(33 * FR + 5);

    // randomized reset points and reset lengths
    for (int seg = 0; seg < 6; seg++) begin
      int hold, len;
      hold = $urandom_range(1, 3);
      len  = $urandom_range(1, 3 * FR);
      for (int h = 0; h < hold; h++) step(1'b1);
      run(len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name:
vga_timing_gen

Overview:
- Generates the scan-position and sync stream that the sprite/palette display blocks consume: DrawX, DrawY, and blank, where blank=1 means active video.
- Also drives the monitor hs/vs.
- Provides copies of hs/vs/blank delayed to match the fixed pixel-path latency of downstream ROM+palette stages.
- Provides a frame-start pulse and a slow animation-frame counter for selecting sprite frames (e.g. sword_down_1..3).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
PIPE_DELAY, 2, cycles of delay on hs_d/vs_d/blank_d; legal range 1..4
ANIM_DIV, 8, frames per animation step; legal range 1..64
ANIM_W, 2, width of anim_frame

Ports:
vga_clk  in  1  pixel clock; all state on rising edge
reset  in  1  synchronous, active-high reset
DrawX  out  10  current horizontal position, 0..H_TOTAL-1
DrawY  out  10  current vertical position, 0..V_TOTAL-1
blank  out  1  1 = active video (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = blanking
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
hs_d  out  1  hs delayed PIPE_DELAY cycles
vs_d  out  1  vs delayed PIPE_DELAY cycles
blank_d  out  1  blank delayed PIPE_DELAY cycles
frame_start  out  1  one-cycle pulse while DrawX=0, DrawY=0
anim_frame  out  ANIM_W  animation frame index, advances every ANIM_DIV frames

Behaviour:
- All outputs are flops. No combinational path from the counters to the outputs.
- hs, vs, blank and frame_start are decoded from the next counter values, so they are aligned with DrawX/DrawY in the same cycle.
- Reset values, applied on any edge with reset=1:
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524).
  - blank=0, hs=1, vs=1, frame_start=0.
  - hs_d=1, vs_d=1, blank_d=0; the whole delay pipe is filled with these idle values.
  - anim_frame=0, internal frame count fcnt=0.
- First edge after reset release: DrawX=0, DrawY=0, blank=1, frame_start=1. Frame 0 pixel 0 is therefore never lost.
- Horizontal counter:
  - DrawX increments by 1 each cycle.
  - At H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 only when DrawX also wraps.
- hs=0 exactly while H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vs=0 exactly while V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491. vs spans whole lines and switches on DrawX=0.
- blank=1 iff DrawX<640 and DrawY<480.
- Delay pipe: hs_d/vs_d/blank_d at cycle n equal hs/vs/blank at cycle n-PIPE_DELAY. It is a shift register that advances every cycle.
- Animation:
  - On each frame_start cycle, fcnt becomes (fcnt+1) mod ANIM_DIV.
  - If the old fcnt = ANIM_DIV-1, anim_frame increments in that same cycle, mod 2^ANIM_W.
  - anim_frame changes only coincident with frame_start, never mid-frame.
  - With ANIM_DIV=1, anim_frame increments on every frame_start.
- Reset mid-operation: all state returns to reset values on the next edge regardless of position. Delay pipe and anim state are cleared too. There are no partial-frame artifacts after release beyond the restart.
- Arithmetic: counters are 10 bits; comparisons are unsigned. Parameter sums must be ≤1023. An out-of-range parameter is a synthesis-time error via an elaboration check.

Test Plan:
1. Reset and release:
   - Hold reset 3 cycles → DrawX=799, DrawY=524, blank=0, hs=vs=1, hs_d=vs_d=1, blank_d=0, anim_frame=0.
   - Release → next cycle DrawX=0, DrawY=0, blank=1, frame_start=1.
   - Following cycle → frame_start=0.
2. Horizontal timing:
   - blank falls when DrawX goes 639→640.
   - hs low for exactly 96 consecutive cycles, DrawX 656..751.
   - Line period 800 cycles; DrawY increments exactly on DrawX 799→0.
3. Vertical timing and wrap:
   - vs low for exactly 1600 cycles, DrawY 490..491.
   - (DrawX,DrawY)=(799,524) → next cycle (0,0) with frame_start=1.
   - frame_start period = 420000 cycles, one pulse per frame.
4. Delay pipe with PIPE_DELAY=2:
   - blank_d first falls 2 cycles after blank, i.e. while DrawX=642.
   - hs_d low while DrawX 658..753.
   - Repeat with PIPE_DELAY=1 and 4; the offset equals the parameter.
5. Animation with ANIM_DIV=8, ANIM_W=2:
   - anim_frame 0→1 on the cycle of the 8th frame_start after reset.
   - Reaches 3 at the 24th and wraps 3→0 on the 32nd.
   - Never changes when frame_start=0.
6. Reset mid-frame:
   - Assert reset at DrawY=200, DrawX=300, after anim_frame=2 → next edge gives reset values, anim_frame=0, delay pipe idle.
   - After release, timing is identical to scenario 1.
